// File: rtl/rename_stage_pkg.sv
// rename_stage_pkg: shared widths, sizes and register-index types for the rename stage
package rename_stage_pkg;
    localparam int AREG_W    = 5;
    localparam int PREG_W    = 7;
    localparam int FL_DEPTH  = 96;
    localparam int UOP_W     = 32;
    localparam int ARCH_REGS = 32;
    localparam int FL_BASE   = 32;
    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/rename_stage_rat.sv
// rat_checkpoint: speculative map table with one shadow copy for branch recovery
module rat_checkpoint
    import rename_stage_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  areg_t rs1,
    input  areg_t rs2,
    input  areg_t rd,
    output preg_t ps1,
    output preg_t ps2,
    output preg_t pd_old,
    input  logic  we,
    input  preg_t wd,
    input  logic  save,
    input  logic  restore
);
    preg_t rat    [ARCH_REGS];
    preg_t shadow [ARCH_REGS];

    assign ps1    = rat[rs1];
    assign ps2    = rat[rs2];
    assign pd_old = rat[rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]    <= preg_t'(i);
                shadow[i] <= preg_t'(i);
            end
        end else begin
            if (restore)
                rat <= shadow;
            else if (we)
                rat[rd] <= wd;
            // the snapshot already includes the branch uop's own destination
            if (save)
                for (int i = 0; i < ARCH_REGS; i++)
                    shadow[i] <= (we && rd == areg_t'(i)) ? wd : rat[i];
        end
    end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps arch regs to phys regs, pops the free list, holds one branch checkpoint
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  areg_t                            in_rs1,
    input  areg_t                            in_rs2,
    input  areg_t                            in_rd,
    input  logic                             in_has_rd,
    input  logic                             in_is_branch,
    input  logic [UOP_W-1:0]                 in_uop,
    output logic                             out_valid,
    input  logic                             out_ready,
    output preg_t                            out_ps1,
    output preg_t                            out_ps2,
    output preg_t                            out_pd_new,
    output preg_t                            out_pd_old,
    output areg_t                            out_rd,
    output logic                             out_has_rd,
    output logic                             out_is_branch,
    output logic [UOP_W-1:0]                 out_uop,
    input  logic                             fl_empty,
    input  preg_t                            fl_pd_new,
    output logic                             fl_read_en,
    input  logic [FL_DEPTH-1:0][PREG_W-1:0]  fl_list_in,
    input  preg_t                            fl_r_ptr_in,
    input  preg_t                            fl_w_ptr_in,
    output logic [FL_DEPTH-1:0][PREG_W-1:0]  cp_list,
    output preg_t                            cp_r_ptr,
    output preg_t                            cp_w_ptr,
    input  logic                             branch_resolve,
    input  logic                             mispredict,
    output logic                             cp_valid
);
    logic  needs_pd, fire, save;
    preg_t ps1, ps2, pd_old;

    // x0 is hardwired, so it never consumes a physical register
    assign needs_pd   = in_has_rd && in_rd != '0;
    assign in_ready   = !mispredict && (!out_valid || out_ready) && !(needs_pd && fl_empty)
                        && !(in_is_branch && cp_valid && !branch_resolve);
    assign fire       = in_valid && in_ready;
    assign fl_read_en = fire && needs_pd;
    assign save       = fire && in_is_branch;

    rat_checkpoint u_rat (
        .clk     (clk),
        .reset   (reset),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .rd      (in_rd),
        .ps1     (ps1),
        .ps2     (ps2),
        .pd_old  (pd_old),
        .we      (fl_read_en),
        .wd      (fl_pd_new),
        .save    (save),
        .restore (mispredict && cp_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_ps1       <= '0;
            out_ps2       <= '0;
            out_pd_new    <= '0;
            out_pd_old    <= '0;
            out_rd        <= '0;
            out_has_rd    <= 1'b0;
            out_is_branch <= 1'b0;
            out_uop       <= '0;
        end else if (mispredict) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid     <= 1'b1;
            out_ps1       <= ps1;
            out_ps2       <= ps2;
            out_pd_new    <= needs_pd ? fl_pd_new : '0;
            out_pd_old    <= pd_old;
            out_rd        <= in_rd;
            out_has_rd    <= in_has_rd;
            out_is_branch <= in_is_branch;
            out_uop       <= in_uop;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cp_valid <= 1'b0;
            cp_r_ptr <= '0;
            cp_w_ptr <= '0;
            for (int i = 0; i < FL_DEPTH; i++)
                cp_list[i] <= preg_t'(i + FL_BASE);
        end else if (mispredict) begin
            cp_valid <= 1'b0;
        end else if (save) begin
            cp_valid <= 1'b1;
            cp_list  <= fl_list_in;
            cp_w_ptr <= fl_w_ptr_in;
            cp_r_ptr <= !needs_pd ? fl_r_ptr_in
                      : (fl_r_ptr_in == preg_t'(FL_DEPTH - 1)) ? '0 : fl_r_ptr_in + 1'b1;
        end else if (branch_resolve) begin
            cp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed-vector self-checking bench for rename_stage
module tb_rename_stage;
    import rename_stage_pkg::*;

    logic clk = 0;
    logic reset, in_valid, in_ready, in_has_rd, in_is_branch;
    areg_t in_rs1, in_rs2, in_rd, out_rd;
    logic [UOP_W-1:0] in_uop, out_uop;
    logic out_valid, out_ready, out_has_rd, out_is_branch;
    preg_t out_ps1, out_ps2, out_pd_new, out_pd_old;
    logic fl_empty, fl_read_en, branch_resolve, mispredict, cp_valid;
    preg_t fl_pd_new, fl_r_ptr_in, fl_w_ptr_in, cp_r_ptr, cp_w_ptr;
    logic [FL_DEPTH-1:0][PREG_W-1:0] fl_list_in, cp_list;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_has_rd(in_has_rd),
        .in_is_branch(in_is_branch), .in_uop(in_uop), .out_valid(out_valid),
        .out_ready(out_ready), .out_ps1(out_ps1), .out_ps2(out_ps2),
        .out_pd_new(out_pd_new), .out_pd_old(out_pd_old), .out_rd(out_rd),
        .out_has_rd(out_has_rd), .out_is_branch(out_is_branch), .out_uop(out_uop),
        .fl_empty(fl_empty), .fl_pd_new(fl_pd_new), .fl_read_en(fl_read_en),
        .fl_list_in(fl_list_in), .fl_r_ptr_in(fl_r_ptr_in), .fl_w_ptr_in(fl_w_ptr_in),
        .cp_list(cp_list), .cp_r_ptr(cp_r_ptr), .cp_w_ptr(cp_w_ptr),
        .branch_resolve(branch_resolve), .mispredict(mispredict), .cp_valid(cp_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input areg_t rs1, input areg_t rs2, input areg_t rd,
                         input logic has_rd, input logic br, input preg_t pd, input logic [31:0] uop);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_has_rd = has_rd; in_is_branch = br; fl_pd_new = pd; in_uop = uop;
        #1;
    endtask

    initial begin
        reset = 1; out_ready = 1; fl_empty = 0; branch_resolve = 0; mispredict = 0;
        fl_r_ptr_in = 0; fl_w_ptr_in = 0;
        for (int i = 0; i < FL_DEPTH; i++) fl_list_in[i] = PREG_W'(i + 40);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        reset = 0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_cp_valid", 32'(cp_valid), 0);
        chk("rst_out_pd_new", 32'(out_pd_new), 0);
        chk("rst_cp_list5", 32'(cp_list[5]), 37);
        chk("rst_cp_r_ptr", 32'(cp_r_ptr), 0);

        drive(1, 3, 4, 5, 1, 0, 32, 32'h100);
        chk("r1_ready", 32'(in_ready), 1);
        chk("r1_pop", 32'(fl_read_en), 1);
        tick;
        chk("r1_valid", 32'(out_valid), 1);
        chk("r1_ps1", 32'(out_ps1), 3);
        chk("r1_ps2", 32'(out_ps2), 4);
        chk("r1_pd_new", 32'(out_pd_new), 32);
        chk("r1_pd_old", 32'(out_pd_old), 5);

        drive(1, 5, 0, 0, 0, 0, 33, 32'h101);
        chk("r2_no_pop", 32'(fl_read_en), 0);
        tick;
        chk("r2_ps1", 32'(out_ps1), 32);

        drive(1, 5, 5, 0, 1, 0, 33, 32'h102);
        chk("x0_no_pop", 32'(fl_read_en), 0);
        tick;
        chk("x0_pd_new", 32'(out_pd_new), 0);
        chk("x0_pd_old", 32'(out_pd_old), 0);

        drive(1, 0, 5, 0, 0, 0, 33, 32'h103);
        tick;
        chk("x0_ps1", 32'(out_ps1), 0);
        chk("x0_rat5", 32'(out_ps2), 32);

        fl_empty = 1;
        drive(1, 1, 2, 6, 1, 0, 33, 32'hA5);
        chk("empty_ready", 32'(in_ready), 0);
        chk("empty_pop", 32'(fl_read_en), 0);
        drive(1, 1, 2, 6, 0, 0, 33, 32'hA5);
        chk("empty_nord_ready", 32'(in_ready), 1);
        tick;
        chk("empty_nord_uop", out_uop, 32'hA5);
        fl_empty = 0;

        drive(1, 1, 2, 8, 1, 0, 34, 32'h11);
        tick;
        out_ready = 0;
        drive(1, 8, 2, 9, 1, 0, 35, 32'h22);
        for (int c = 0; c < 3; c++) begin
            chk("hold_ready", 32'(in_ready), 0);
            chk("hold_pop", 32'(fl_read_en), 0);
            tick;
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_pd_new", 32'(out_pd_new), 34);
            chk("hold_uop", out_uop, 32'h11);
        end
        out_ready = 1;
        #1;
        chk("release_ready", 32'(in_ready), 1);
        tick;
        chk("release_uop", out_uop, 32'h22);
        chk("release_ps1", 32'(out_ps1), 34);
        chk("release_pd_new", 32'(out_pd_new), 35);

        fl_r_ptr_in = 95; fl_w_ptr_in = 10; fl_list_in[0] = 7'd99;
        drive(1, 9, 8, 7, 1, 1, 36, 32'h33);
        tick;
        chk("br_cp_valid", 32'(cp_valid), 1);
        chk("br_cp_r_ptr_wrap", 32'(cp_r_ptr), 0);
        chk("br_cp_w_ptr", 32'(cp_w_ptr), 10);
        chk("br_cp_list0", 32'(cp_list[0]), 99);
        chk("br_out_is_branch", 32'(out_is_branch), 1);
        chk("br_pd_old", 32'(out_pd_old), 7);

        drive(1, 7, 0, 7, 1, 0, 40, 32'h44);
        tick;
        chk("spec_pd_old", 32'(out_pd_old), 36);
        chk("spec_pd_new", 32'(out_pd_new), 40);

        mispredict = 1;
        drive(1, 7, 0, 7, 1, 0, 41, 32'h55);
        chk("mp_ready", 32'(in_ready), 0);
        chk("mp_pop", 32'(fl_read_en), 0);
        tick;
        mispredict = 0;
        chk("mp_out_valid", 32'(out_valid), 0);
        chk("mp_cp_valid", 32'(cp_valid), 0);
        drive(1, 7, 8, 0, 0, 0, 41, 32'h56);
        tick;
        chk("mp_rat7_restored", 32'(out_ps1), 36);
        chk("mp_rat8_kept", 32'(out_ps2), 34);

        fl_r_ptr_in = 20;
        drive(1, 1, 1, 0, 0, 1, 41, 32'h60);
        tick;
        chk("br2_cp_valid", 32'(cp_valid), 1);
        chk("br2_cp_r_ptr", 32'(cp_r_ptr), 20);
        fl_r_ptr_in = 50;
        drive(1, 1, 1, 10, 1, 1, 41, 32'h61);
        chk("br3_blocked", 32'(in_ready), 0);
        branch_resolve = 1;
        #1;
        chk("br3_resolve_ready", 32'(in_ready), 1);
        tick;
        chk("br3_cp_valid", 32'(cp_valid), 1);
        chk("br3_cp_r_ptr", 32'(cp_r_ptr), 51);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        branch_resolve = 0;
        chk("resolve_clears", 32'(cp_valid), 0);

        drive(1, 0, 0, 10, 1, 0, 42, 32'h62);
        tick;
        mispredict = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        mispredict = 0;
        chk("mp_nocp_flush", 32'(out_valid), 0);
        drive(1, 10, 0, 0, 0, 0, 0, 32'h63);
        tick;
        chk("mp_nocp_rat10", 32'(out_ps1), 42);

        drive(1, 2, 5, 5, 1, 1, 43, 32'h70);
        reset = 1;
        tick;
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_cp_valid", 32'(cp_valid), 0);
        drive(1, 5, 7, 0, 0, 0, 0, 32'h71);
        tick;
        chk("rst2_rat5", 32'(out_ps1), 5);
        chk("rst2_rat7", 32'(out_ps2), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage between decode and dispatch.
- Reads source mappings from a speculative map table (RAT) and pops a fresh physical destination from free_list on each rd write.
- Emits renamed uop with ps1/ps2/pd_new/pd_old through a one-entry output register.
- Holds a single branch checkpoint (RAT + free-list state) and restores it on mispredict.

Parameters:
- AREG_W, 5, architectural register index width (32 arch regs)
- PREG_W, 7, physical register index width (128 phys regs)
- FL_DEPTH, 96, free-list entries; must match free_list
- UOP_W, 32, opaque payload carried unchanged to dispatch

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  decode has a uop
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2, in_rd  in  AREG_W each  architectural sources/dest
- in_has_rd  in  1  uop writes rd
- in_is_branch  in  1  uop takes a checkpoint
- in_uop  in  UOP_W  payload
- out_valid  out  1  renamed uop valid
- out_ready  in  1  dispatch accepts
- out_ps1, out_ps2, out_pd_new, out_pd_old  out  PREG_W each  renamed operands
- out_rd  out  AREG_W; out_has_rd  out  1; out_is_branch  out  1; out_uop  out  UOP_W
- fl_empty  in  1  free list empty
- fl_pd_new  in  PREG_W  free-list head
- fl_read_en  out  1  pop free list
- fl_list_in  in  PREG_W x FL_DEPTH  free-list contents
- fl_r_ptr_in, fl_w_ptr_in  in  PREG_W  free-list pointers
- cp_list  out  PREG_W x FL_DEPTH  checkpointed list, to free_list re_list
- cp_r_ptr, cp_w_ptr  out  PREG_W  checkpointed pointers
- branch_resolve  in  1  checkpointed branch resolved correct
- mispredict  in  1  checkpointed branch mispredicted; also drives free_list mispredict
- cp_valid  out  1  checkpoint held

Behaviour:
- Reset: RAT[i]=i for all i; cp_valid=0; out_valid=0; all out_* data=0; checkpoint RAT=identity; cp_list[i]=i+32; cp_r_ptr=cp_w_ptr=0.
- needs_pd = in_has_rd && in_rd!=0. x0 is never renamed: pd_new=0, pd_old=0, no pop.
- in_ready = !mispredict && (!out_valid || out_ready) && !(needs_pd && fl_empty) && !(in_is_branch && cp_valid && !branch_resolve).
- fire = in_valid && in_ready; fl_read_en = fire && needs_pd (combinational, same cycle).
- On fire:
  - out_ps1=RAT[in_rs1], out_ps2=RAT[in_rs2], read before this uop's own update.
  - out_pd_old=RAT[in_rd]; out_pd_new=fl_pd_new.
  - RAT[in_rd] <= fl_pd_new if needs_pd.
  - Register the payload; out_valid<=1. Latency: 1 cycle accept-to-out_valid.
- Output hold: if out_valid && !out_ready, all out_* remain stable. out_valid clears when out_ready && !fire.
- Checkpoint capture (fire && in_is_branch):
  - Snapshot RAT including this uop's update; cp_list<=fl_list_in; cp_w_ptr<=fl_w_ptr_in.
  - cp_r_ptr<=fl_r_ptr_in+1 (wrap FL_DEPTH-1 -> 0) if needs_pd, else fl_r_ptr_in.
  - cp_valid<=1.
- branch_resolve: cp_valid<=0, unless a new branch fires the same cycle; then the new checkpoint is captured and cp_valid stays 1.
- mispredict (highest priority):
  - If cp_valid, RAT<=checkpoint RAT.
  - out_valid<=0; cp_valid<=0; no accept, no pop that cycle.
  - mispredict with cp_valid=0: flush only, RAT unchanged.
- Simultaneous mispredict and branch_resolve: mispredict wins.
- Reset mid-operation returns all state to reset values on the next edge; the in-flight uop is dropped.

Decomposition:
- Shared package: AREG_W, PREG_W, FL_DEPTH, ARCH_REGS=32, FL_BASE=32, preg_t and areg_t typedefs.
- Sub-module rat_checkpoint: RAT array, one shadow copy, read ports, write port, save/restore controls.
- rename_stage keeps handshake, free-list interface and output register.

Test Plan:
- Reset, rename rs1=3,rs2=4,rd=5 with fl_pd_new=32 -> next cycle ps1=3, ps2=4, pd_new=32, pd_old=5, fl_read_en pulsed once; following uop reading rs1=5 -> ps1=32.
- rd=0 with in_has_rd=1 -> pd_new=0, pd_old=0, fl_read_en stays 0, RAT unchanged.
- fl_empty=1 with needs_pd -> in_ready=0, no pop; uop with in_has_rd=0 still fires.
- out_ready=0 for 3 cycles after a rename -> outputs stable, in_ready=0; out_ready=1 -> next uop accepted that cycle.
- Branch fires with fl_r_ptr_in=95 and needs_pd -> cp_r_ptr=0. Rename rd=7 to 40; mispredict -> RAT[7] equals branch-time value, out_valid=0, cp_valid=0.
- Second branch while cp_valid=1 -> in_ready=0. branch_resolve same cycle -> accepted, cp_valid stays 1.
